// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int UART_DATA_BITS = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and registered status.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty_q;
    assign push_ok = push && (!full_q || pop_ok);

    assign wr_ptr_d = wr_ptr_q + LW'(push_ok);
    assign rd_ptr_d = rd_ptr_q + LW'(pop_ok);
    assign level_d  = wr_ptr_d - rd_ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == LW'(DEPTH));
            empty_q  <= (level_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;

endmodule

// File: rtl/uart_tx_fifo_ser.sv
// Buffered 8N1 UART transmitter fed by register-block write strobes.
module uart_tx_fifo_ser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH = 16,
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESETN,
    input  logic               i_wr_en,
    input  logic [7:0]         i_wr_data,
    input  logic               i_clr_ovf,
    output logic               o_full,
    output logic               o_empty,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_overflow,
    output logic               o_tx_serial,
    output logic               o_tx_active,
    output logic               o_tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    tx_state_t                 state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [IDX_W-1:0]          idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic                      serial_q;
    logic                      active_q;
    logic                      done_q;
    logic                      ovf_q, ovf_d;

    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      drop;

    assign fifo_pop = (state_q == IDLE) && !fifo_empty;
    assign drop     = i_wr_en && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (S_AXI_ACLK),
        .rst_n (S_AXI_ARESETN),
        .push  (i_wr_en),
        .pop   (fifo_pop),
        .din   (i_wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_level)
    );

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q  <= START;
                        cnt_q    <= '0;
                        shift_q  <= fifo_dout;
                        serial_q <= 1'b0;
                        active_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= DATA;
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        serial_q <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q  <= STOP;
                            serial_q <= 1'b1;
                        end else begin
                            idx_q    <= idx_q + 1'b1;
                            shift_q  <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
                            serial_q <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        active_q <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        // Raised one cycle early so it lands on the last STOP cycle.
                        done_q <= (cnt_q == CNT_PRE);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_full      = fifo_full;
    assign o_empty     = fifo_empty;
    assign o_overflow  = ovf_q;
    assign o_tx_serial = serial_q;
    assign o_tx_active = active_q;
    assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_ser.sv
// Randomised bench for uart_tx_fifo_ser with a frame-timing model and line receiver.
module tb_uart_tx_fifo_ser;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam int FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          clr = 1'b0;
    logic          full, empty, ovf, tx, act, done;
    logic [LW-1:0] level;
    logic [8:0]    obs;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo_ser #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .i_wr_en       (wr_en),
        .i_wr_data     (wr_data),
        .i_clr_ovf     (clr),
        .o_full        (full),
        .o_empty       (empty),
        .o_level       (level),
        .o_overflow    (ovf),
        .o_tx_serial   (tx),
        .o_tx_active   (act),
        .o_tx_done     (done)
    );

    always #5 clk = ~clk;

    assign obs = {tx, act, done, full, empty, ovf, level};

    // Reference model: queue of stored bytes plus remaining cycles of the current frame.
    logic [7:0] mq[$];
    logic [7:0] sent_q[$];
    logic [7:0] cur = 8'h00;
    int         busy = 0;
    bit         m_ovf = 0;
    bit         m_pop, m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            busy = 0;
            m_ovf = 0;
        end else begin
            m_pop  = (busy == 0) && (mq.size() > 0);
            m_drop = wr_en && (mq.size() == DEPTH) && !m_pop;
            if (busy > 0) busy--;
            if (m_pop) begin
                cur = mq.pop_front();
                sent_q.push_back(cur);
                busy = FRAME;
            end
            if (wr_en && !m_drop) mq.push_back(wr_data);
            if (m_drop) m_ovf = 1;
            else if (clr) m_ovf = 0;
        end
    end

    function automatic logic [8:0] exp_vec();
        logic line;
        int b;
        line = 1'b1;
        if (busy > 0) begin
            b = (FRAME - busy) / CPB;
            if (b == 0) line = 1'b0;
            else if (b <= 8) line = cur[b-1];
        end
        return {line, busy > 0, busy == 1, mq.size() == DEPTH,
                mq.size() == 0, m_ovf, LW'(mq.size())};
    endfunction

    // Independent line receiver sampling at bit centres.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = 8'h00;
    bit         rx_busy = 0;
    int         rx_cnt = 0;
    int         rx_k;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_busy = 0;
            rx_cnt = 0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                rx_k = rx_cnt / CPB;
                if (rx_k >= 1 && rx_k <= 8) rx_sh[rx_k-1] = tx;
                else if (rx_k == 9) begin
                    if (tx === 1'b1) rx_q.push_back(rx_sh);
                    rx_busy = 0;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 9'b100010000) begin
            errors++;
            $display("FAIL reset_state got %b expected %b", obs, 9'b100010000);
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if ({tx, act, empty, level} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
                errors++;
                $display("FAIL idle_line got %b expected %b",
                         {tx, act, empty, level}, 6'b101000);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] bits_exp;
        logic [FRAME+3:0] line_s;
        int done_n, done_at;
        bits_exp = 10'b1101001010;
        done_n = 0;
        done_at = -1;
        rx_q.delete();
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'hA5;
        for (int c = 0; c < FRAME + 4; c++) begin
            @(negedge clk);
            wr_en = 1'b0;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL single_cycle c=%0d got %b expected %b", c, obs, exp_vec());
            end
            line_s[c] = tx;
            if (done) begin
                done_n++;
                done_at = c;
            end
        end
        checks++;
        if (line_s[1:0] !== 2'b01) begin
            errors++;
            $display("FAIL start_latency got %b expected %b", line_s[1:0], 2'b01);
        end
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (line_s[1 + CPB*b + CPB/2] !== bits_exp[b]) begin
                errors++;
                $display("FAIL a5_bit%0d got %b expected %b",
                         b, line_s[1 + CPB*b + CPB/2], bits_exp[b]);
            end
        end
        checks++;
        if (done_n != 1 || done_at != FRAME) begin
            errors++;
            $display("FAIL a5_done got n=%0d at=%0d expected n=1 at=%0d", done_n, done_at, FRAME);
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL a5_rx got size %0d expected 1 byte a5", rx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d[3];
        bit act_s[3*(FRAME+1)+10];
        int lvl_max, done_n, first, last, gaps;
        d = '{8'h01, 8'h80, 8'hFF};
        lvl_max = 0;
        done_n = 0;
        first = -1;
        last = -1;
        gaps = 0;
        rx_q.delete();
        for (int c = 0; c < 3*(FRAME+1)+10; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_cycle c=%0d got %b expected %b", c, obs, exp_vec());
            end
            if (int'(level) > lvl_max) lvl_max = int'(level);
            if (done) done_n++;
            act_s[c] = act;
            wr_en = (c < 3);
            if (c < 3) wr_data = d[c];
        end
        for (int c = 0; c < 3*(FRAME+1)+10; c++) begin
            if (act_s[c]) begin
                if (first < 0) first = c;
                last = c;
            end
        end
        for (int c = first; c <= last && first >= 0; c++) begin
            if (!act_s[c]) gaps++;
        end
        checks++;
        if (lvl_max != 2) begin
            errors++;
            $display("FAIL b2b_level_peak got %0d expected 2", lvl_max);
        end
        checks++;
        if (done_n != 3) begin
            errors++;
            $display("FAIL b2b_done_count got %0d expected 3", done_n);
        end
        checks++;
        if (gaps != 2) begin
            errors++;
            $display("FAIL b2b_idle_gaps got %0d expected 2", gaps);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_q.size() <= i || rx_q[i] !== d[i]) begin
                errors++;
                $display("FAIL b2b_rx%0d got size %0d expected byte %h", i, rx_q.size(), d[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_rx[5];
        bit saw_full, saw_ovf;
        exp_rx = '{8'h0F, 8'h10, 8'h11, 8'h12, 8'h13};
        saw_full = 0;
        saw_ovf = 0;
        rx_q.delete();
        for (int c = 0; c < 5*(FRAME+1)+15; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL ovf_cycle c=%0d got %b expected %b", c, obs, exp_vec());
            end
            if (full) saw_full = 1;
            if (ovf) saw_ovf = 1;
            if (c == 13) begin
                checks++;
                if (ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_clear got %b expected 0", ovf);
                end
            end
            wr_en = (c == 0) || (c >= 3 && c <= 8);
            wr_data = (c == 0) ? 8'h0F : 8'(8'h10 + c - 3);
            clr = (c == 12);
        end
        clr = 1'b0;
        checks++;
        if (!saw_full || !saw_ovf) begin
            errors++;
            $display("FAIL ovf_flags got full=%0d ovf=%0d expected 1 1", saw_full, saw_ovf);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_q.size() != 5 || rx_q[i] !== exp_rx[i]) begin
                errors++;
                $display("FAIL ovf_rx%0d got size %0d expected byte %h", i, rx_q.size(), exp_rx[i]);
            end
        end
    endtask

    task automatic test_full_pop();
        int pc;
        pc = -1;
        rx_q.delete();
        for (int c = 0; c < 6*(FRAME+1)+20; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL fullpop_cycle c=%0d got %b expected %b", c, obs, exp_vec());
            end
            if (pc >= 0 && c == pc + 1) begin
                checks++;
                if ({ovf, full, level} !== {1'b0, 1'b1, 3'd4}) begin
                    errors++;
                    $display("FAIL fullpop_accept got %b expected %b", {ovf, full, level}, 5'b01100);
                end
            end
            wr_en = 1'b0;
            if (c == 0 || (c >= 3 && c <= 6)) begin
                wr_en = 1'b1;
                wr_data = 8'(8'h20 + (c == 0 ? 0 : c - 2));
            end else if (pc < 0 && c > 6 && busy == 0 && mq.size() == DEPTH) begin
                wr_en = 1'b1;
                wr_data = 8'h25;
                pc = c;
            end
        end
        checks++;
        if (pc < 0) begin
            errors++;
            $display("FAIL fullpop_window got none expected a pop cycle");
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rx_q.size() != 6 || rx_q[i] !== 8'(8'h20 + i)) begin
                errors++;
                $display("FAIL fullpop_rx%0d got size %0d expected byte %h", i, rx_q.size(), 8'(8'h20 + i));
            end
        end
    endtask

    task automatic test_random();
        int c;
        rx_q.delete();
        sent_q.delete();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL rand_cycle i=%0d got %b expected %b", i, obs, exp_vec());
            end
            wr_en = ($urandom_range(0, 9) < 2);
            wr_data = 8'($urandom);
            clr = ($urandom_range(0, 19) == 0);
        end
        wr_en = 1'b0;
        clr = 1'b0;
        c = 0;
        while ((busy > 0 || mq.size() > 0) && c < (DEPTH+2)*(FRAME+1)) begin
            @(negedge clk);
            c++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL rand_drain c=%0d got %b expected %b", c, obs, exp_vec());
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy > 0 || mq.size() > 0) begin
            errors++;
            $display("FAIL rand_drain_timeout got level %0d expected 0", level);
        end
        checks++;
        if (rx_q != sent_q) begin
            errors++;
            $display("FAIL rand_rx got %0d bytes expected %0d bytes", rx_q.size(), sent_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            wr_en = (c < 3);
            wr_data = 8'(8'h5A + c);
            if (busy > 0 && FRAME - busy == 4*CPB + 1) hit = 1;
        end
        wr_en = 1'b0;
        checks++;
        if (!hit || level == 0) begin
            errors++;
            $display("FAIL mid_setup got hit=%0d level=%0d expected hit=1 level>0", hit, level);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx, act, level, empty} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset got %b expected %b", {tx, act, level, empty}, 6'b100001);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        for (int c = 0; c < 2*FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec() || tx !== 1'b1) begin
                errors++;
                $display("FAIL post_reset c=%0d got %b expected %b", c, obs, exp_vec());
            end
        end
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_rx got %0d bytes expected 0", rx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
